// File: rtl/uart_frame_checker.sv
// ----------------------------------------------------------------------------
// uart_frame_checker
//
// Purpose:
//   Frame checker for the UART receive path. It takes the sampler's decided
//   bits (one per bit_vld strobe), deserialises DATA_WIDTH data bits LSB-first,
//   computes parity as the bits arrive, checks the parity bit (even/odd/mark/
//   space) and one or two stop bits, and delivers the word with per-frame
//   error flags. Two saturating counters accumulate parity and stop errors
//   for the register block.
//
// Parameters:
//   DATA_WIDTH  data bits per frame (5..9)
//   CNT_WIDTH   width of each saturating error counter
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sampled_bit  line value decided by the sampler
//   bit_vld      one-cycle strobe: sampled_bit holds a decided bit
//   PAR_EN       parity bit present (latched at start bit)
//   par_mode     00 even, 01 odd, 10 mark, 11 space (latched at start bit)
//   stop2        two stop bits (latched at start bit)
//   frame_abort  synchronous return to IDLE, no delivery
//   cnt_clr      synchronous clear of both error counters
//   P_DATA       received word, held until the next completed frame
//   data_vld     one-cycle frame-complete pulse
//   par_err      parity error of the last completed frame
//   stp_err      stop-bit error of the last completed frame
//   busy         high whenever the FSM is not IDLE
//   par_err_cnt  saturating parity-error count
//   stp_err_cnt  saturating stop-error count
// ----------------------------------------------------------------------------
module uart_frame_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sampled_bit,
    input  logic                  bit_vld,
    input  logic                  PAR_EN,
    input  logic [1:0]            par_mode,
    input  logic                  stop2,
    input  logic                  frame_abort,
    input  logic                  cnt_clr,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_vld,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

    localparam int BC_W = $clog2(DATA_WIDTH);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP1  = 3'd3,
        STOP2  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Frame configuration captured at the start bit.
    logic                  r_par_en;
    logic [1:0]            r_par_mode;
    logic                  r_stop2;

    logic [BC_W-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_acc;
    logic                  r_par_flag;
    logic                  r_stp_flag;

    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_vld;
    logic                  r_par_err;
    logic                  r_stp_err;
    logic [CNT_WIDTH-1:0]  r_par_cnt;
    logic [CNT_WIDTH-1:0]  r_stp_cnt;

    logic                  w_accept;
    logic                  w_done;
    logic                  w_par_exp;
    logic                  w_frame_par_err;

    // Abort has priority over a coincident strobe and also cancels delivery
    // if it lands in the DONE cycle.
    assign w_accept        = bit_vld & ~frame_abort;
    assign w_done          = (r_state == DONE) & ~frame_abort;
    assign w_frame_par_err = r_par_flag & r_par_en;

    always_comb begin
        case (r_par_mode)
            2'b00:   w_par_exp = r_acc;
            2'b01:   w_par_exp = ~r_acc;
            2'b10:   w_par_exp = 1'b1;
            default: w_par_exp = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: w_next_state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        if (frame_abort) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:   if (bit_vld && !sampled_bit) w_next_state = DATA;
                DATA:   if (bit_vld && r_bit_cnt == LAST_BIT)
                            w_next_state = r_par_en ? PARITY : STOP1;
                PARITY: if (bit_vld) w_next_state = STOP1;
                STOP1:  if (bit_vld) w_next_state = r_stop2 ? STOP2 : DONE;
                STOP2:  if (bit_vld) w_next_state = DONE;
                DONE:   w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_en   <= 1'b0;
            r_par_mode <= 2'b00;
            r_stop2    <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_acc      <= 1'b0;
            r_par_flag <= 1'b0;
            r_stp_flag <= 1'b0;
            r_p_data   <= '0;
            r_data_vld <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
            r_par_cnt  <= '0;
            r_stp_cnt  <= '0;
        end else begin
            r_data_vld <= 1'b0;

            if (w_accept) begin
                case (r_state)
                    IDLE: if (!sampled_bit) begin
                        r_par_en   <= PAR_EN;
                        r_par_mode <= par_mode;
                        r_stop2    <= stop2;
                        r_bit_cnt  <= '0;
                        r_shift    <= '0;
                        r_acc      <= 1'b0;
                        r_par_flag <= 1'b0;
                        r_stp_flag <= 1'b0;
                    end
                    DATA: begin
                        // LSB-first: after DATA_WIDTH shifts the first bit sits in [0].
                        r_shift   <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
                        r_acc     <= r_acc ^ sampled_bit;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    PARITY:       r_par_flag <= (sampled_bit != w_par_exp);
                    STOP1, STOP2: r_stp_flag <= r_stp_flag | ~sampled_bit;
                    default: ;
                endcase
            end

            if (w_done) begin
                r_p_data   <= r_shift;
                r_par_err  <= w_frame_par_err;
                r_stp_err  <= r_stp_flag;
                r_data_vld <= 1'b1;
            end

            // Clear beats a same-cycle increment.
            if (cnt_clr) begin
                r_par_cnt <= '0;
                r_stp_cnt <= '0;
            end else if (w_done) begin
                if (w_frame_par_err && r_par_cnt != '1) r_par_cnt <= r_par_cnt + 1'b1;
                if (r_stp_flag && r_stp_cnt != '1)      r_stp_cnt <= r_stp_cnt + 1'b1;
            end
        end
    end

    assign P_DATA      = r_p_data;
    assign data_vld    = r_data_vld;
    assign par_err     = r_par_err;
    assign stp_err     = r_stp_err;
    assign busy        = (r_state != IDLE);
    assign par_err_cnt = r_par_cnt;
    assign stp_err_cnt = r_stp_cnt;

endmodule

// File: tb/tb_uart_frame_checker.sv
// ----------------------------------------------------------------------------
// tb_uart_frame_checker
//
// Directed bench for uart_frame_checker with DATA_WIDTH=8 and CNT_WIDTH=2 so
// counter saturation is reachable in a few frames. Inputs change 1 ns after
// the rising edge and outputs are sampled there as well.
// ----------------------------------------------------------------------------
module tb_uart_frame_checker;

    logic       clk;
    logic       rst_n;
    logic       sampled_bit;
    logic       bit_vld;
    logic       PAR_EN;
    logic [1:0] par_mode;
    logic       stop2;
    logic       frame_abort;
    logic       cnt_clr;
    logic [7:0] P_DATA;
    logic       data_vld;
    logic       par_err;
    logic       stp_err;
    logic       busy;
    logic [1:0] par_err_cnt;
    logic [1:0] stp_err_cnt;

    int total = 0;
    int bad   = 0;

    uart_frame_checker #(
        .DATA_WIDTH (8),
        .CNT_WIDTH  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sampled_bit (sampled_bit),
        .bit_vld     (bit_vld),
        .PAR_EN      (PAR_EN),
        .par_mode    (par_mode),
        .stop2       (stop2),
        .frame_abort (frame_abort),
        .cnt_clr     (cnt_clr),
        .P_DATA      (P_DATA),
        .data_vld    (data_vld),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy),
        .par_err_cnt (par_err_cnt),
        .stp_err_cnt (stp_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b);
        sampled_bit = b;
        bit_vld     = 1'b1;
        tick();
        bit_vld     = 1'b0;
        sampled_bit = 1'b1;
    endtask

    // Start bit, 8 data bits LSB-first, optional parity bit, one stop bit.
    task automatic send_frame(input logic [7:0] d, input logic has_par,
                              input logic pb, input logic s1);
        strobe(1'b0);
        for (int i = 0; i < 8; i++) strobe(d[i]);
        if (has_par) strobe(pb);
        strobe(s1);
    endtask

    // Called just after the edge that accepted the final stop bit.
    task automatic done_check(input string tag, input logic [7:0] ed,
                              input logic ep, input logic es,
                              input logic [1:0] epc, input logic [1:0] esc);
        chk({tag, "_vld_early"}, data_vld, 1'b0);
        chk({tag, "_busy_done"}, busy, 1'b1);
        tick();
        chk({tag, "_vld"},     data_vld, 1'b1);
        chk({tag, "_data"},    P_DATA, ed);
        chk({tag, "_par_err"}, par_err, ep);
        chk({tag, "_stp_err"}, stp_err, es);
        chk({tag, "_pcnt"},    par_err_cnt, epc);
        chk({tag, "_scnt"},    stp_err_cnt, esc);
        chk({tag, "_busy"},    busy, 1'b0);
        tick();
        chk({tag, "_vld_pulse"}, data_vld, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        sampled_bit = 1'b1;
        bit_vld     = 1'b0;
        PAR_EN      = 1'b1;
        par_mode    = 2'b00;
        stop2       = 1'b0;
        frame_abort = 1'b0;
        cnt_clr     = 1'b0;
        repeat (3) tick();
        chk("rst_data", P_DATA, 8'h00);
        chk("rst_vld",  data_vld, 1'b0);
        chk("rst_perr", par_err, 1'b0);
        chk("rst_serr", stp_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pcnt", par_err_cnt, 2'd0);
        chk("rst_scnt", stp_err_cnt, 2'd0);
        rst_n = 1'b1;
        tick();

        // Idle-line strobes keep the FSM in IDLE.
        strobe(1'b1);
        chk("idle_stay", busy, 1'b0);

        // Even parity, 0xA5 (four ones) -> parity bit 0 is correct.
        strobe(1'b0);
        chk("start_busy", busy, 1'b1);
        for (int i = 0; i < 8; i++) strobe(1'((8'hA5 >> i) & 8'h01));
        strobe(1'b0);
        strobe(1'b1);
        done_check("even_ok", 8'hA5, 1'b0, 1'b0, 2'd0, 2'd0);

        // Odd parity, 0xA5 with parity 0 -> error. A start-like strobe in the
        // DONE cycle must be ignored.
        par_mode = 2'b01;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        sampled_bit = 1'b0;
        bit_vld     = 1'b1;
        chk("odd_err_vld_early", data_vld, 1'b0);
        tick();
        bit_vld     = 1'b0;
        sampled_bit = 1'b1;
        chk("odd_err_vld",  data_vld, 1'b1);
        chk("odd_err_perr", par_err, 1'b1);
        chk("odd_err_pcnt", par_err_cnt, 2'd1);
        chk("done_strobe_ignored", busy, 1'b0);
        tick();

        // Odd parity, 0x01 with parity 0 -> correct, count holds.
        send_frame(8'h01, 1'b1, 1'b0, 1'b1);
        done_check("odd_ok", 8'h01, 1'b0, 1'b0, 2'd1, 2'd0);

        // Mark expects 1; space expects 0.
        par_mode = 2'b10;
        send_frame(8'h00, 1'b1, 1'b0, 1'b1);
        done_check("mark", 8'h00, 1'b1, 1'b0, 2'd2, 2'd0);
        par_mode = 2'b11;
        send_frame(8'h00, 1'b1, 1'b0, 1'b1);
        done_check("space", 8'h00, 1'b0, 1'b0, 2'd2, 2'd0);

        // No parity: the 9th bit after start is the stop bit.
        PAR_EN = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        done_check("nopar", 8'h5A, 1'b0, 1'b0, 2'd2, 2'd0);

        // Two stop bits latched at start; config change mid-frame ignored.
        PAR_EN   = 1'b1;
        par_mode = 2'b00;
        stop2    = 1'b1;
        strobe(1'b0);
        stop2    = 1'b0;
        PAR_EN   = 1'b0;
        for (int i = 0; i < 8; i++) strobe(1'((8'h3C >> i) & 8'h01));
        strobe(1'b0);
        strobe(1'b0);
        tick();
        chk("stop2_wait_vld",  data_vld, 1'b0);
        chk("stop2_wait_busy", busy, 1'b1);
        strobe(1'b1);
        done_check("stop2", 8'h3C, 1'b0, 1'b1, 2'd2, 2'd1);

        // Further stop errors saturate the 2-bit counter.
        PAR_EN = 1'b1;
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        done_check("sat2", 8'h00, 1'b0, 1'b1, 2'd2, 2'd2);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        done_check("sat3", 8'h00, 1'b0, 1'b1, 2'd2, 2'd3);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        done_check("sat4", 8'h00, 1'b0, 1'b1, 2'd2, 2'd3);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        done_check("sat5", 8'h00, 1'b0, 1'b1, 2'd2, 2'd3);

        // Sixth error with cnt_clr on the increment cycle -> clear wins.
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_vld",  data_vld, 1'b1);
        chk("clr_serr", stp_err, 1'b1);
        chk("clr_scnt", stp_err_cnt, 2'd0);
        chk("clr_pcnt", par_err_cnt, 2'd0);
        tick();

        // Good frame so P_DATA holds 0xA5, then abort overlapping a strobe.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        done_check("pre_abort", 8'hA5, 1'b0, 1'b0, 2'd0, 2'd0);
        strobe(1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1);
        frame_abort = 1'b1;
        strobe(1'b0);
        frame_abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_vld",  data_vld, 1'b0);
        for (int i = 0; i < 6; i++) strobe(1'b1);
        chk("abort_idle_vld", data_vld, 1'b0);
        chk("abort_idle",     busy, 1'b0);
        chk("abort_data",     P_DATA, 8'hA5);

        // Abort without strobe from PARITY-bound DATA, then a clean frame.
        strobe(1'b0);
        strobe(1'b1);
        frame_abort = 1'b1;
        tick();
        frame_abort = 1'b0;
        chk("abort2_busy", busy, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        done_check("post_abort", 8'h81, 1'b0, 1'b0, 2'd0, 2'd0);

        // Asynchronous reset mid-DATA clears outputs without a clock edge.
        strobe(1'b0);
        for (int i = 0; i < 3; i++) strobe(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data", P_DATA, 8'h00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_vld",  data_vld, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_checker.md
Name: uart_frame_checker

Overview:
- Parametrised successor to the single-byte parity checker in the UART RX path.
- Consumes the sampler's per-bit strobe, deserialises LSB-first data of configurable width and computes parity on the fly.
- Checks the parity bit in even/odd/mark/space modes and checks one or two stop bits.
- Emits the data word with per-frame error flags plus saturating error counters for the register block.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal 5..9.
- CNT_WIDTH, 8, width of each saturating error counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sampled_bit  in  1  current oversampled line value from the sampler.
- bit_vld  in  1  one-cycle strobe: sampled_bit holds a decided bit.
- PAR_EN  in  1  parity bit present.
- par_mode  in  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0).
- stop2  in  1  1 = two stop bits.
- frame_abort  in  1  synchronous abort to IDLE.
- cnt_clr  in  1  synchronous clear of both counters.
- P_DATA  out  DATA_WIDTH  received word.
- data_vld  out  1  one-cycle frame-complete pulse.
- par_err  out  1  parity error of last completed frame.
- stp_err  out  1  stop-bit error of last completed frame.
- busy  out  1  high in any state other than IDLE.
- par_err_cnt  out  CNT_WIDTH  saturating parity-error count.
- stp_err_cnt  out  CNT_WIDTH  saturating stop-error count.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: all outputs 0, FSM IDLE, shift register and parity accumulator 0. Reset mid-frame discards the frame with no data_vld.
- The FSM advances only on cycles with bit_vld=1, except frame_abort and the DONE state. All transitions and output updates are registered.
- States and transitions:
  - IDLE: on bit_vld with sampled_bit=1, stay. On bit_vld with sampled_bit=0 (start bit), latch PAR_EN, par_mode and stop2 into shadow registers, clear the bit counter, shift register, parity accumulator and internal error bits, then go to DATA. Config changes mid-frame are ignored.
  - DATA: each bit_vld shifts sampled_bit in LSB-first (first data bit ends in P_DATA[0]) and does acc ^= bit. After DATA_WIDTH bits, go to PARITY if shadow PAR_EN=1, else STOP1.
  - PARITY: expected bit = acc (even), ~acc (odd), 1 (mark), 0 (space). Internal par flag = (sampled_bit != expected). Go to STOP1.
  - STOP1: stop flag |= ~sampled_bit. Go to STOP2 if shadow stop2=1, else DONE.
  - STOP2: stop flag |= ~sampled_bit. Go to DONE. A stop error in STOP1 does not skip STOP2.
  - DONE (one cycle, no strobe needed): load P_DATA, par_err and stp_err, pulse data_vld, then go to IDLE.
- Latency: data_vld is high exactly one cycle after the clock edge that accepts the final stop bit's bit_vld. Any bit_vld in the DONE cycle is ignored.
- Output hold: P_DATA, par_err and stp_err hold their values until the next DONE. par_err is forced 0 at DONE when shadow PAR_EN=0. Error frames still deliver data_vld.
- Counters: each counter increments by 1 at DONE when its flag is set and saturates at all-ones, with no wrap.
  - cnt_clr zeroes both counters.
  - cnt_clr in the same cycle as an increment: clear wins, result 0.
- frame_abort: from any state, go to IDLE next cycle with no data_vld. Outputs and counters are unchanged. When frame_abort and bit_vld coincide, abort wins. frame_abort in IDLE has no effect.
- busy = (state != IDLE), including the DONE cycle.

Test Plan:
- DATA_WIDTH=8, even parity, one stop bit; frame start, 0xA5 LSB-first, parity 0, stop 1 -> P_DATA=0xA5, data_vld one cycle after the stop strobe, par_err=0, stp_err=0, counters 0.
- Odd parity, 0xA5, parity bit 0 -> par_err=1, par_err_cnt=1. Next frame, odd parity, 0x01 with parity 0 -> par_err=0, par_err_cnt stays 1.
- Mark mode, 0x00 with parity 0 -> par_err=1. Space mode, same bit -> par_err=0. PAR_EN=0, 9 bits after start -> the 9th bit is treated as stop, and par_err=0.
- stop2=1, 0x3C, stop bits 0 then 1 -> stp_err=1, data_vld only after the second stop. Changing stop2 to 0 mid-frame leaves the frame at two stops.
- CNT_WIDTH=2, five consecutive stop-error frames -> stp_err_cnt = 1, 2, 3, 3, 3. cnt_clr on the same cycle as the sixth error -> 0.
- frame_abort after 4 data bits, also overlapping a bit_vld -> IDLE next cycle, no data_vld, P_DATA keeps the previous 0xA5. rst_n low mid-DATA -> all outputs 0 immediately.
